// File: rtl/sequencer_pkg.sv
// Shared codes for the micro-sequencer: micro-state codes, opcode and
// sub-op encodings, jump conditions, the sequencer phase type and a decode helper.
package sequencer_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned SUB_W  = 3;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned INSTR_W = 8;

    // Micro-state codes seen by control; IDLE asserts no strobes.
    localparam logic [CODE_W-1:0] STATE_IDLE       = 8'h00;
    localparam logic [CODE_W-1:0] STATE_FETCH_PC   = 8'h01;
    localparam logic [CODE_W-1:0] STATE_FETCH_INST = 8'h02;
    localparam logic [CODE_W-1:0] STATE_ALU_EXEC   = 8'h03;
    localparam logic [CODE_W-1:0] STATE_ALU_OUT    = 8'h04;
    localparam logic [CODE_W-1:0] STATE_MOV_REG    = 8'h05;
    localparam logic [CODE_W-1:0] STATE_SET_REG    = 8'h06;
    localparam logic [CODE_W-1:0] STATE_LOAD_ADDR  = 8'h07;
    localparam logic [CODE_W-1:0] STATE_SET_MAR    = 8'h08;
    localparam logic [CODE_W-1:0] STATE_SET_MEM    = 8'h09;
    localparam logic [CODE_W-1:0] STATE_FETCH_SP   = 8'h0A;
    localparam logic [CODE_W-1:0] STATE_STACK_REG  = 8'h0B;
    localparam logic [CODE_W-1:0] STATE_INC_SP     = 8'h0C;
    localparam logic [CODE_W-1:0] STATE_JUMP       = 8'h0D;
    localparam logic [CODE_W-1:0] STATE_STORE_PC   = 8'h0E;
    localparam logic [CODE_W-1:0] STATE_TMP_JUMP   = 8'h0F;
    localparam logic [CODE_W-1:0] STATE_RET        = 8'h10;
    localparam logic [CODE_W-1:0] STATE_HALT       = 8'h11;

    // Major opcode, ir[7:6].
    localparam logic [OP_W-1:0] OP_ALU = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV = 2'b01;
    localparam logic [OP_W-1:0] OP_MEM = 2'b10;
    localparam logic [OP_W-1:0] OP_CTL = 2'b11;

    // MEM sub-ops live in operand2 (ir[2:0]).
    localparam logic [SUB_W-1:0] MEM_LDI  = 3'b000;
    localparam logic [SUB_W-1:0] MEM_LDA  = 3'b001;
    localparam logic [SUB_W-1:0] MEM_LDR  = 3'b010;
    localparam logic [SUB_W-1:0] MEM_STR  = 3'b011;
    localparam logic [SUB_W-1:0] MEM_PUSH = 3'b100;
    localparam logic [SUB_W-1:0] MEM_POP  = 3'b101;

    // CTL sub-ops live in operand1 (ir[5:3]).
    localparam logic [SUB_W-1:0] CTL_JCC  = 3'b000;
    localparam logic [SUB_W-1:0] CTL_CALL = 3'b001;
    localparam logic [SUB_W-1:0] CTL_RET  = 3'b010;
    localparam logic [SUB_W-1:0] CTL_NOP  = 3'b011;
    localparam logic [SUB_W-1:0] CTL_HALT = 3'b111;

    // Jump conditions carried in operand2 of Jcc; decoded by control.
    localparam logic [SUB_W-1:0] JMP_ALWAYS = 3'b000;
    localparam logic [SUB_W-1:0] JMP_Z      = 3'b001;
    localparam logic [SUB_W-1:0] JMP_NZ     = 3'b010;
    localparam logic [SUB_W-1:0] JMP_C      = 3'b011;
    localparam logic [SUB_W-1:0] JMP_NC     = 3'b100;

    // Where the sequencer is in the fetch/execute loop; distinguishes an
    // exec-step FETCH_PC from the fetch FETCH_PC that shares its code.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH_PC,
        PH_FETCH_INST,
        PH_EXEC,
        PH_HALT
    } phase_e;

    // Sub-op field: CTL uses operand1, everything else uses operand2.
    function automatic logic [SUB_W-1:0] sub_of(input logic [INSTR_W-1:0] instr);
        sub_of = (instr[7:6] == OP_CTL) ? instr[5:3] : instr[2:0];
    endfunction

endpackage

// File: rtl/seq_rom.sv
// Combinational micro-sequence table.
//  op, sub      decoded opcode and sub-op of the instruction
//  idx          index of the exec step being looked up
//  next_state   code of exec step idx, or FETCH_PC once the sequence is exhausted
//  none         idx is past the end of the sequence
//  illegal      op/sub is an undefined opcode
module seq_rom
    import sequencer_pkg::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic [OP_W-1:0]   op,
    input  logic [SUB_W-1:0]  sub,
    input  logic [STEP_W-1:0] idx,
    output logic [CODE_W-1:0] next_state,
    output logic              none,
    output logic              illegal
);

    logic [CODE_W-1:0] seq0;
    logic [CODE_W-1:0] seq1;
    logic [CODE_W-1:0] seq2;
    logic [STEP_W-1:0] len;

    // Per-instruction sequence, then select step idx.
    always_comb begin
        seq0       = STATE_IDLE;
        seq1       = STATE_IDLE;
        seq2       = STATE_IDLE;
        len        = '0;
        illegal    = 1'b0;
        next_state = STATE_FETCH_PC;
        none       = 1'b1;

        case (op)
            OP_ALU: begin
                seq0 = STATE_ALU_EXEC;
                seq1 = STATE_ALU_OUT;
                len  = 2'd2;
            end
            OP_MOV: begin
                seq0 = STATE_MOV_REG;
                len  = 2'd1;
            end
            OP_MEM: begin
                case (sub)
                    MEM_LDI: begin
                        seq0 = STATE_FETCH_PC;
                        seq1 = STATE_SET_REG;
                        len  = 2'd2;
                    end
                    MEM_LDA: begin
                        seq0 = STATE_FETCH_PC;
                        seq1 = STATE_LOAD_ADDR;
                        seq2 = STATE_SET_REG;
                        len  = 2'd3;
                    end
                    MEM_LDR: begin
                        seq0 = STATE_SET_MAR;
                        seq1 = STATE_SET_REG;
                        len  = 2'd2;
                    end
                    MEM_STR: begin
                        seq0 = STATE_SET_MAR;
                        seq1 = STATE_SET_MEM;
                        len  = 2'd2;
                    end
                    MEM_PUSH: begin
                        seq0 = STATE_FETCH_SP;
                        seq1 = STATE_STACK_REG;
                        len  = 2'd2;
                    end
                    MEM_POP: begin
                        seq0 = STATE_INC_SP;
                        seq1 = STATE_FETCH_SP;
                        seq2 = STATE_SET_REG;
                        len  = 2'd3;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_CTL: begin
                case (sub)
                    CTL_JCC: begin
                        seq0 = STATE_FETCH_PC;
                        seq1 = STATE_JUMP;
                        len  = 2'd2;
                    end
                    CTL_CALL: begin
                        seq0 = STATE_FETCH_SP;
                        seq1 = STATE_STORE_PC;
                        seq2 = STATE_TMP_JUMP;
                        len  = 2'd3;
                    end
                    CTL_RET: begin
                        seq0 = STATE_INC_SP;
                        seq1 = STATE_FETCH_SP;
                        seq2 = STATE_RET;
                        len  = 2'd3;
                    end
                    CTL_NOP: len = 2'd0;
                    CTL_HALT: begin
                        seq0 = STATE_HALT;
                        len  = 2'd1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: ;
        endcase

        // Undefined opcodes run as NOP (empty sequence) or as HALT.
        if (illegal && ILLEGAL_HALTS) begin
            seq0 = STATE_HALT;
            len  = 2'd1;
        end

        none = (idx >= len);
        case (idx)
            2'd0:    next_state = seq0;
            2'd1:    next_state = seq1;
            2'd2:    next_state = seq2;
            default: next_state = STATE_FETCH_PC;
        endcase
        if (none) begin
            next_state = STATE_FETCH_PC;
        end
    end

endmodule

// File: rtl/sequencer.sv
// Micro-sequencer: fetches an instruction from the bus, decodes it and steps
// through its micro-state sequence, presenting the current code to control.
//  clk, rst_n   clock; synchronous active-low reset
//  en           step enable; all registers hold while low
//  bus          instruction byte, sampled in FETCH_INST
//  state        micro-state code (IDLE while stalled, HALT while halted)
//  operand1/2   ir[5:3] / ir[2:0] of the latched instruction
//  halted       high while halted
//  illegal      pulse when an undefined opcode is decoded
//  instr_done   pulse in the last execute state of each instruction
module sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned STATE_W       = 8,
    parameter bit          ILLEGAL_HALTS = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [7:0]         bus,
    output logic [STATE_W-1:0] state,
    output logic [2:0]         operand1,
    output logic [2:0]         operand2,
    output logic               halted,
    output logic               illegal,
    output logic               instr_done
);

    phase_e              phase;
    logic [STATE_W-1:0]  state_r;
    logic [INSTR_W-1:0]  ir;
    logic [STEP_W-1:0]   step;
    logic                halted_r;
    logic                halt_done_r;

    logic                decoding;
    logic [INSTR_W-1:0]  instr_sel;
    logic [SUB_W-1:0]    sub_sel;
    logic [STEP_W-1:0]   idx_sel;
    logic [CODE_W-1:0]   rom_next;
    logic                rom_none;
    logic                rom_illegal;

    // In FETCH_INST ir is not yet loaded, so decode straight from the bus;
    // in exec look up the step after the current one.
    assign decoding  = (phase == PH_FETCH_INST);
    assign instr_sel = decoding ? bus : ir;
    assign sub_sel   = sub_of(instr_sel);
    assign idx_sel   = decoding ? '0 : STEP_W'(step + STEP_W'(1));

    seq_rom #(
        .ILLEGAL_HALTS (ILLEGAL_HALTS)
    ) u_rom (
        .op         (instr_sel[7:6]),
        .sub        (sub_sel),
        .idx        (idx_sel),
        .next_state (rom_next),
        .none       (rom_none),
        .illegal    (rom_illegal)
    );

    // Fetch/execute loop; HALT is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= PH_IDLE;
            state_r     <= STATE_W'(STATE_IDLE);
            ir          <= '0;
            step        <= '0;
            halted_r    <= 1'b0;
            halt_done_r <= 1'b0;
        end else begin
            halt_done_r <= 1'b0;
            if (en && !halted_r) begin
                case (phase)
                    PH_IDLE: begin
                        phase   <= PH_FETCH_PC;
                        state_r <= STATE_W'(STATE_FETCH_PC);
                    end
                    PH_FETCH_PC: begin
                        phase   <= PH_FETCH_INST;
                        state_r <= STATE_W'(STATE_FETCH_INST);
                    end
                    PH_FETCH_INST, PH_EXEC: begin
                        // step indexes the exec state being entered; after
                        // the last one it rests at the sequence length.
                        if (decoding) begin
                            ir   <= bus;
                            step <= '0;
                        end else begin
                            step <= STEP_W'(step + STEP_W'(1));
                        end
                        if (rom_none) begin
                            phase   <= PH_FETCH_PC;
                            state_r <= STATE_W'(STATE_FETCH_PC);
                        end else if (rom_next == STATE_HALT) begin
                            phase       <= PH_HALT;
                            state_r     <= STATE_W'(STATE_HALT);
                            halted_r    <= 1'b1;
                            halt_done_r <= 1'b1;
                        end else begin
                            phase   <= PH_EXEC;
                            state_r <= STATE_W'(rom_next);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A stalled cycle shows IDLE so control never repeats a strobe.
    assign state      = halted_r ? STATE_W'(STATE_HALT)
                                 : (en ? state_r : STATE_W'(STATE_IDLE));
    assign operand1   = ir[5:3];
    assign operand2   = ir[2:0];
    assign halted     = halted_r;
    assign illegal    = en && !halted_r && decoding && rom_illegal;
    // Done when no further exec step follows; NOP completes in FETCH_INST.
    assign instr_done = halt_done_r ||
                        (en && !halted_r && (decoding || phase == PH_EXEC) && rom_none);

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the micro-sequencer: reset, ALU, POP with stall,
// CALL/RET, exec-step FETCH_PC, NOP, illegal opcodes, HALT, halting illegal.
module tb_sequencer;

    localparam logic [7:0] S_IDLE      = 8'h00;
    localparam logic [7:0] S_FPC       = 8'h01;
    localparam logic [7:0] S_FINST     = 8'h02;
    localparam logic [7:0] S_ALU_EXEC  = 8'h03;
    localparam logic [7:0] S_ALU_OUT   = 8'h04;
    localparam logic [7:0] S_SET_REG   = 8'h06;
    localparam logic [7:0] S_LOAD_ADDR = 8'h07;
    localparam logic [7:0] S_FETCH_SP  = 8'h0A;
    localparam logic [7:0] S_INC_SP    = 8'h0C;
    localparam logic [7:0] S_STORE_PC  = 8'h0E;
    localparam logic [7:0] S_TMP_JUMP  = 8'h0F;
    localparam logic [7:0] S_RET       = 8'h10;
    localparam logic [7:0] S_HALT      = 8'h11;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [7:0] bus;
    logic [7:0] state;
    logic [2:0] operand1, operand2;
    logic       halted, illegal, instr_done;

    logic       rst_n_h, en_h;
    logic [7:0] bus_h;
    logic [7:0] state_h;
    logic [2:0] operand1_h, operand2_h;
    logic       halted_h, illegal_h, instr_done_h;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sequencer #(.STATE_W(8), .ILLEGAL_HALTS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .state(state),
        .operand1(operand1), .operand2(operand2), .halted(halted),
        .illegal(illegal), .instr_done(instr_done)
    );

    sequencer #(.STATE_W(8), .ILLEGAL_HALTS(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n_h), .en(en_h), .bus(bus_h), .state(state_h),
        .operand1(operand1_h), .operand2(operand2_h), .halted(halted_h),
        .illegal(illegal_h), .instr_done(instr_done_h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; bus = 8'h00;
        tick(); tick();
        vectors++;
        if ({state, operand1, operand2, halted, illegal, instr_done} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: state=%h op1=%0d op2=%0d halted=%b illegal=%b done=%b expected all 0",
                     state, operand1, operand2, halted, illegal, instr_done);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (state !== S_IDLE) begin
            miscompares++; $display("FAIL reset_idle: state=%h expected %h", state, S_IDLE);
        end
        tick();
        vectors++;
        if (state !== S_FPC) begin
            miscompares++; $display("FAIL reset_fetch_pc: state=%h expected %h", state, S_FPC);
        end
        tick();
        vectors++;
        if (state !== S_FINST) begin
            miscompares++; $display("FAIL reset_fetch_inst: state=%h expected %h", state, S_FINST);
        end
    endtask

    task automatic test_alu();
        logic [7:0] exp_s [3];
        logic       exp_d;
        exp_s = '{S_ALU_EXEC, S_ALU_OUT, S_FPC};
        bus = 8'b00_001_010;
        #1;
        vectors++;
        if (state !== S_FINST || instr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_decode: state=%h done=%b expected %h 0", state, instr_done, S_FINST);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            bus = 8'hFF;
            #1;
            exp_d = (i == 1);
            vectors++;
            if (state !== exp_s[i] || instr_done !== exp_d || operand1 !== 3'd1 || operand2 !== 3'd2) begin
                miscompares++;
                $display("FAIL alu_step%0d: state=%h done=%b op1=%0d op2=%0d expected %h %b 1 2",
                         i, state, instr_done, operand1, operand2, exp_s[i], exp_d);
            end
        end
        tick();
    endtask

    task automatic test_pop_stall();
        bus = 8'b10_011_101;
        #1;
        vectors++;
        if (state !== S_FINST) begin
            miscompares++; $display("FAIL pop_decode: state=%h expected %h", state, S_FINST);
        end
        tick();
        vectors++;
        if (state !== S_INC_SP) begin
            miscompares++; $display("FAIL pop_inc_sp: state=%h expected %h", state, S_INC_SP);
        end
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            vectors++;
            if (state !== S_IDLE || instr_done !== 1'b0 || operand1 !== 3'd3 || operand2 !== 3'd5) begin
                miscompares++;
                $display("FAIL pop_stall%0d: state=%h done=%b op1=%0d op2=%0d expected %h 0 3 5",
                         i, state, instr_done, operand1, operand2, S_IDLE);
            end
        end
        tick();
        en = 1'b1;
        #1;
        vectors++;
        if (state !== S_FETCH_SP || instr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_resume: state=%h done=%b expected %h 0", state, instr_done, S_FETCH_SP);
        end
        tick();
        vectors++;
        if (state !== S_SET_REG || instr_done !== 1'b1) begin
            miscompares++;
            $display("FAIL pop_set_reg: state=%h done=%b expected %h 1", state, instr_done, S_SET_REG);
        end
        tick();
        vectors++;
        if (state !== S_FPC) begin
            miscompares++; $display("FAIL pop_back_fetch: state=%h expected %h", state, S_FPC);
        end
        tick();
    endtask

    task automatic test_call_ret();
        logic [7:0] exp_s [2][4];
        logic [7:0] instr [2];
        int         ndone;
        exp_s = '{'{S_FETCH_SP, S_STORE_PC, S_TMP_JUMP, S_FPC},
                  '{S_INC_SP, S_FETCH_SP, S_RET, S_FPC}};
        instr = '{8'b11_001_000, 8'b11_010_000};
        for (int j = 0; j < 2; j++) begin
            bus = instr[j];
            #1;
            vectors++;
            if (state !== S_FINST) begin
                miscompares++; $display("FAIL callret%0d_decode: state=%h expected %h", j, state, S_FINST);
            end
            ndone = int'(instr_done);
            for (int i = 0; i < 4; i++) begin
                tick();
                vectors++;
                if (state !== exp_s[j][i]) begin
                    miscompares++;
                    $display("FAIL callret%0d_step%0d: state=%h expected %h", j, i, state, exp_s[j][i]);
                end
                ndone += int'(instr_done);
            end
            vectors++;
            if (ndone !== 1) begin
                miscompares++; $display("FAIL callret%0d_done_count: got %0d expected 1", j, ndone);
            end
            tick();
        end
    endtask

    task automatic test_exec_fetch_pc();
        logic [7:0] exp_s [2][4];
        logic [7:0] instr [2];
        int         len [2];
        logic       exp_d;
        exp_s = '{'{S_FPC, S_SET_REG, S_FPC, S_FINST},
                  '{S_FPC, S_LOAD_ADDR, S_SET_REG, S_FPC}};
        instr = '{8'b10_001_000, 8'b10_010_001};
        len   = '{2, 3};
        for (int j = 0; j < 2; j++) begin
            bus = instr[j];
            #1;
            for (int i = 0; i <= len[j]; i++) begin
                tick();
                exp_d = (i == len[j] - 1);
                vectors++;
                if (state !== exp_s[j][i] || instr_done !== exp_d) begin
                    miscompares++;
                    $display("FAIL ldx%0d_step%0d: state=%h done=%b expected %h %b",
                             j, i, state, instr_done, exp_s[j][i], exp_d);
                end
            end
            tick();
            vectors++;
            if (state !== S_FINST) begin
                miscompares++; $display("FAIL ldx%0d_refetch: state=%h expected %h", j, state, S_FINST);
            end
        end
    endtask

    task automatic test_nop();
        bus = 8'b11_011_000;
        #1;
        vectors++;
        if (state !== S_FINST || instr_done !== 1'b1 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_decode: state=%h done=%b illegal=%b expected %h 1 0",
                     state, instr_done, illegal, S_FINST);
        end
        tick();
        vectors++;
        if (state !== S_FPC || instr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_next: state=%h done=%b expected %h 0", state, instr_done, S_FPC);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [7:0] instr [2];
        instr = '{8'b10_000_110, 8'b11_100_000};
        for (int j = 0; j < 2; j++) begin
            bus = instr[j];
            #1;
            vectors++;
            if (illegal !== 1'b1 || instr_done !== 1'b1 || state !== S_FINST) begin
                miscompares++;
                $display("FAIL illegal%0d_decode: illegal=%b done=%b state=%h expected 1 1 %h",
                         j, illegal, instr_done, state, S_FINST);
            end
            tick();
            vectors++;
            if (illegal !== 1'b0 || state !== S_FPC || halted !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal%0d_next: illegal=%b state=%h halted=%b expected 0 %h 0",
                         j, illegal, state, halted, S_FPC);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        bus = 8'hFF;
        #1;
        tick();
        vectors++;
        if (state !== S_HALT || halted !== 1'b1 || instr_done !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_enter: state=%h halted=%b done=%b expected %h 1 1",
                     state, halted, instr_done, S_HALT);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            en = i[0];
            #1;
            vectors++;
            if (state !== S_HALT || halted !== 1'b1 || instr_done !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_sticky%0d: state=%h halted=%b done=%b expected %h 1 0",
                         i, state, halted, instr_done, S_HALT);
            end
        end
        rst_n = 1'b0; en = 1'b1;
        tick();
        vectors++;
        if (state !== S_IDLE || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset: state=%h halted=%b expected %h 0", state, halted, S_IDLE);
        end
        rst_n = 1'b1;
        tick(); tick();
        vectors++;
        if (state !== S_FINST) begin
            miscompares++; $display("FAIL halt_restart: state=%h expected %h", state, S_FINST);
        end
    endtask

    task automatic test_illegal_halts();
        rst_n_h = 1'b0; en_h = 1'b1; bus_h = 8'h00;
        tick();
        rst_n_h = 1'b1;
        tick(); tick();
        bus_h = 8'b10_000_110;
        #1;
        vectors++;
        if (state_h !== S_FINST || illegal_h !== 1'b1) begin
            miscompares++;
            $display("FAIL ilh_decode: state=%h illegal=%b expected %h 1", state_h, illegal_h, S_FINST);
        end
        tick();
        vectors++;
        if (state_h !== S_HALT || halted_h !== 1'b1 || illegal_h !== 1'b0) begin
            miscompares++;
            $display("FAIL ilh_halt: state=%h halted=%b illegal=%b expected %h 1 0",
                     state_h, halted_h, illegal_h, S_HALT);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; bus = 8'h00;
        rst_n_h = 1'b0; en_h = 1'b1; bus_h = 8'h00;
        test_reset();
        test_alu();
        test_pop_stall();
        test_call_ret();
        test_exec_fetch_pc();
        test_nop();
        test_illegal();
        test_halt();
        test_illegal_halts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
